ysyx_24090003_ifu: RTL and testbench

Instruction fetch unit, directly upstream of decode/immediate generation. Holds the architectural PC. Issues one outstanding 32-bit read per instruction on a valid/ready instruction-memory port. Presents {inst, pc, fault} to decode on a valid/ready handshake. Accepts a redirect (branch/jump/trap target) from execute and discards any wrong-path fetch.

---
 rtl/ysyx_24090003_pkg.sv | 14 +
 rtl/ysyx_24090003_pcgen.sv | 38 +++
 rtl/ysyx_24090003_ifu.sv | 147 ++++++++++++++
 tb/tb_ysyx_24090003_ifu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24090003_pkg.sv
// Shared definitions for the instruction fetch unit: width, reset PC and FSM encoding.
package ysyx_24090003_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // Fetch sequencing: issue request, wait for response, present to decode.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_24090003_pcgen.sv
// Architectural PC register with next-PC selection: hold, +4, or redirect target.
module ysyx_24090003_pcgen #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_inc,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;

  // Redirect has priority over sequential advance; +4 wraps naturally at 2^XLEN.
  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect) begin
      w_pc_next = i_redirect_pc;
    end else if (i_inc) begin
      w_pc_next = r_pc + XLEN'(4);
    end
  end

  // PC register, returns to the boot address on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_24090003_ifu.sv
// Instruction fetch unit: one outstanding imem read, registered decode interface,
// redirect handling with wrong-path response discard.
module ysyx_24090003_ifu #(
  parameter int          XLEN     = ysyx_24090003_pkg::XLEN,
  parameter logic [31:0] RESET_PC = ysyx_24090003_pkg::DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic            id_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  import ysyx_24090003_pkg::*;

  state_e          r_state, w_state_next;
  logic            r_drop, w_drop_next;
  logic            r_id_valid, w_id_valid_next;
  logic [XLEN-1:0] r_id_inst, w_id_inst_next;
  logic [XLEN-1:0] r_id_pc, w_id_pc_next;
  logic            r_id_fault, w_id_fault_next;
  logic [XLEN-1:0] w_pc;
  logic            w_pc_inc;
  logic            w_pc_redir;
  logic            w_misaligned;

  ysyx_24090003_pcgen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pcgen (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_inc         (w_pc_inc),
    .i_redirect    (w_pc_redir),
    .i_redirect_pc (redirect_pc),
    .o_pc          (w_pc)
  );

  // A misaligned PC never reaches memory; it is reported to decode as a fault.
  assign w_misaligned   = (w_pc[1:0] != 2'b00);
  assign imem_req_valid = rst_n && (r_state == S_REQ) && !w_misaligned;
  assign imem_req_addr  = w_pc;

  // Next-state, drop flag, decode-register and PC-control selection.
  always_comb begin
    w_state_next    = r_state;
    w_drop_next     = r_drop;
    w_id_valid_next = r_id_valid;
    w_id_inst_next  = r_id_inst;
    w_id_pc_next    = r_id_pc;
    w_id_fault_next = r_id_fault;
    w_pc_inc        = 1'b0;
    w_pc_redir      = 1'b0;
    case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_pc_redir = 1'b1;
          // A request accepted together with a redirect is already wrong-path.
          if (!w_misaligned && imem_req_ready) begin
            w_state_next = S_WAIT;
            w_drop_next  = 1'b1;
          end
        end else if (w_misaligned) begin
          w_state_next    = S_OUT;
          w_id_valid_next = 1'b1;
          w_id_inst_next  = '0;
          w_id_pc_next    = w_pc;
          w_id_fault_next = 1'b1;
        end else if (imem_req_ready) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_redir = 1'b1;
          if (imem_resp_valid) begin
            // The in-flight response is stale; go fetch the new target.
            w_drop_next  = 1'b0;
            w_state_next = S_REQ;
          end else begin
            w_drop_next = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (r_drop) begin
            w_drop_next  = 1'b0;
            w_state_next = S_REQ;
          end else begin
            w_id_valid_next = 1'b1;
            w_id_inst_next  = imem_resp_data;
            w_id_pc_next    = w_pc;
            w_id_fault_next = imem_resp_err;
            w_state_next    = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          w_pc_redir      = 1'b1;
          w_id_valid_next = 1'b0;
          w_state_next    = S_REQ;
        end else if (id_ready) begin
          w_pc_inc        = 1'b1;
          w_id_valid_next = 1'b0;
          w_state_next    = S_REQ;
        end
      end
      default: begin
        w_state_next = S_REQ;
      end
    endcase
  end

  // State and decode-side output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_REQ;
      r_drop     <= 1'b0;
      r_id_valid <= 1'b0;
      r_id_inst  <= '0;
      r_id_pc    <= '0;
      r_id_fault <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_drop     <= w_drop_next;
      r_id_valid <= w_id_valid_next;
      r_id_inst  <= w_id_inst_next;
      r_id_pc    <= w_id_pc_next;
      r_id_fault <= w_id_fault_next;
    end
  end

  assign id_valid = r_id_valid;
  assign id_inst  = r_id_inst;
  assign id_pc    = r_id_pc;
  assign id_fault = r_id_fault;

endmodule

// File: tb/tb_ysyx_24090003_ifu.sv
// Testbench for the fetch unit: directed scenarios followed by randomized traffic
// checked against an architectural-PC reference model and a simple memory model.
module tb_ysyx_24090003_ifu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_24090003_ifu dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_inst         (id_inst),
    .id_pc           (id_pc),
    .id_fault        (id_fault),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory contents and bus-error map of the model memory.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a[6:2] == 5'h1F);
  endfunction

  // Apply inputs for the next rising edge, then return at the following falling edge.
  task automatic tick(input logic rr, input logic rv, input logic [31:0] rd, input logic re,
                      input logic idr, input logic rdv, input logic [31:0] rpc);
    imem_req_ready  = rr;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    imem_resp_err   = re;
    id_ready        = idr;
    redirect_valid  = rdv;
    redirect_pc     = rpc;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_id_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_id_inst"}, id_inst, 32'd0);
    chk({tag, "_id_pc"}, id_pc, 32'd0);
    chk({tag, "_id_fault"}, 32'(id_fault), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic        pending, pend_before;
    logic [31:0] paddr;
    int          wcnt, idle, delivered;
    logic        s_rv, s_idv, s_idf;
    logic [31:0] s_addr, s_idpc, s_idinst;
    logic        rr, rv, re, idr, rdv;
    logic [31:0] rd, rpc;

    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0; imem_resp_err = 0;
    id_ready = 0; redirect_valid = 0; redirect_pc = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    chk("rel_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rel_req_addr", imem_req_addr, 32'h8000_0000);

    // Zero-wait fetch, decode ready
    tick(1, 0, 0, 0, 0, 0, 0);
    chk("t1_wait_noreq", 32'(imem_req_valid), 32'd0);
    tick(0, 1, 32'h0000_0013, 0, 1, 0, 0);
    chk("t1_id_valid", 32'(id_valid), 32'd1);
    chk("t1_id_pc", id_pc, 32'h8000_0000);
    chk("t1_id_inst", id_inst, 32'h0000_0013);
    chk("t1_id_fault", 32'(id_fault), 32'd0);
    tick(0, 0, 0, 0, 1, 0, 0);
    chk("t1_next_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_next_addr", imem_req_addr, 32'h8000_0004);
    $display("T dir1 pc=80000000 inst=00000013");

    // Decode back-pressure for 5 cycles
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 32'hCAFE_0001, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(id_valid), 32'd1);
      chk("t2_hold_inst", id_inst, 32'hCAFE_0001);
      chk("t2_hold_pc", id_pc, 32'h8000_0004);
      chk("t2_hold_noreq", 32'(imem_req_valid), 32'd0);
      tick(0, 0, 0, 0, 0, 0, 0);
    end
    tick(0, 0, 0, 0, 1, 0, 0);
    chk("t2_next_addr", imem_req_addr, 32'h8000_0008);
    $display("T dir2 pc=80000004 inst=cafe0001");

    // Redirect during wait, stale response discarded
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1, 32'h8000_0100);
    tick(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
    chk("t3_no_id_valid", 32'(id_valid), 32'd0);
    chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t3_req_addr", imem_req_addr, 32'h8000_0100);
    $display("T dir3 redirect in wait -> 80000100");

    // Redirect beats id_ready in output state
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 32'h1111_1111, 0, 0, 0, 0);
    chk("t4_id_pc", id_pc, 32'h8000_0100);
    tick(0, 0, 0, 0, 1, 1, 32'h8000_0200);
    chk("t4_req_addr", imem_req_addr, 32'h8000_0200);
    chk("t4_id_valid", 32'(id_valid), 32'd0);
    $display("T dir4 redirect over ready -> 80000200");

    // Bus error, then misaligned redirect
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 32'h2222_2222, 1, 0, 0, 0);
    chk("t5_err_fault", 32'(id_fault), 32'd1);
    chk("t5_err_pc", id_pc, 32'h8000_0200);
    tick(0, 0, 0, 0, 0, 1, 32'h8000_0002);
    chk("t5_mis_noreq", 32'(imem_req_valid), 32'd0);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("t5_mis_valid", 32'(id_valid), 32'd1);
    chk("t5_mis_fault", 32'(id_fault), 32'd1);
    chk("t5_mis_inst", id_inst, 32'd0);
    chk("t5_mis_pc", id_pc, 32'h8000_0002);
    $display("T dir5 fault pc=80000200, misaligned pc=80000002");

    // PC wrap at top of address space
    tick(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    chk("t6_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 32'h0000_0033, 0, 0, 0, 0);
    chk("t6_top_pc", id_pc, 32'hFFFF_FFFC);
    tick(0, 0, 0, 0, 1, 0, 0);
    chk("t6_wrap_addr", imem_req_addr, 32'h0000_0000);
    $display("T dir6 pc=fffffffc wraps to 00000000");

    // Asynchronous reset in the middle of a wait
    tick(1, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t7");
    tick(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    // Stray response outside the wait state must be ignored
    tick(0, 1, 32'h5555_5555, 1, 0, 0, 0);
    chk("t7_stray_req", 32'(imem_req_valid), 32'd1);
    chk("t7_stray_addr", imem_req_addr, 32'h8000_0000);
    chk("t7_stray_idv", 32'(id_valid), 32'd0);
    $display("T dir7 async reset and stray response");

    // Randomized traffic against the architectural model
    exp_pc = 32'h8000_0000;
    pending = 0; paddr = 0; wcnt = 0; idle = 0; delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s_rv = imem_req_valid; s_addr = imem_req_addr;
      s_idv = id_valid; s_idpc = id_pc; s_idinst = id_inst; s_idf = id_fault;
      pend_before = pending;

      rr  = ($urandom_range(9) < 6);
      idr = ($urandom_range(9) < 7);
      rdv = ($urandom_range(11) == 0);
      case ($urandom_range(15))
        0:       rpc = 32'hFFFF_FFFC;
        1, 2:    rpc = 32'h8000_0000 + 32'($urandom_range(63)) * 4 + 32'($urandom_range(3, 1));
        default: rpc = 32'h8000_0000 + 32'($urandom_range(63)) * 4;
      endcase
      if (pending) begin
        if (wcnt == 0) begin
          rv = 1; rd = mem_word(paddr); re = mem_err(paddr); pending = 0;
        end else begin
          rv = 0; rd = $urandom; re = 0; wcnt--;
        end
      end else begin
        rv = ($urandom_range(19) == 0); rd = $urandom; re = 1'($urandom_range(1));
      end

      if (s_idv) begin
        chk("rnd_id_pc", s_idpc, exp_pc);
        chk("rnd_id_inst", s_idinst, (exp_pc[1:0] != 0) ? 32'd0 : mem_word(exp_pc));
        chk("rnd_id_fault", 32'(s_idf), 32'((exp_pc[1:0] != 0) || mem_err(exp_pc)));
      end
      if (s_rv) begin
        chk("rnd_req_addr", s_addr, exp_pc);
        chk("rnd_one_outstanding", 32'(pend_before), 32'd0);
        chk("rnd_req_while_idv", 32'(s_idv), 32'd0);
      end
      if (exp_pc[1:0] != 0) chk("rnd_mis_noreq", 32'(s_rv), 32'd0);

      if (s_rv && rr) begin
        pending = 1; paddr = s_addr; wcnt = $urandom_range(2);
      end
      if (rdv) begin
        exp_pc = rpc;
      end else if (s_idv && idr) begin
        delivered++;
        $display("T%0d pc=%h inst=%h fault=%0d", delivered, s_idpc, s_idinst, s_idf);
        exp_pc = exp_pc + 32'd4;
      end

      if (s_idv || rdv) idle = 0;
      else idle++;
      if (idle > 60) begin
        chk("rnd_watchdog", 32'(idle), 32'd0);
        break;
      end

      tick(rr, rv, rd, re, idr, rdv, rpc);
    end
    chk("rnd_progress", 32'(delivered > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
